radix4_digit_serializer: RTL

Converts a parallel two's-complement fractional operand into a stream of radix-4 signed digits, most significant digit (MSD) first, one digit per transfer. It is the transmitter that feeds the `x`/`y` digit inputs of the online radix-4 multiplier. Optionally it appends `DELTA` zero digits after each operand so the multiplier's online delay drains before the next frame. Digits are produced by radix-4 Booth recoding, so every digit lies in {-2..2}, a subset of the multiplier's {-3..3} digit set.

---
 rtl/radix4_digit_serializer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/radix4_digit_serializer.sv
// Parallel two's-complement fraction -> radix-4 Booth digit stream, MSD first.
// Define RADIX4_SERIALIZER_FLUSH_EN to append DELTA zero pad digits per frame.
module radix4_digit_serializer #(
  parameter int NO_OF_DIGITS = 4,
  parameter int RADIX_BITS   = 3,
  parameter int DELTA        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*NO_OF_DIGITS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [RADIX_BITS-1:0]     dig_out,
  output logic                      dig_valid,
  input  logic                      dig_ready,
  output logic                      dig_first,
  output logic                      dig_last
);

  localparam int OP_W = 2 * NO_OF_DIGITS;
`ifdef RADIX4_SERIALIZER_FLUSH_EN
  localparam int FRAME_LEN = NO_OF_DIGITS + DELTA;
`else
  localparam int FRAME_LEN = NO_OF_DIGITS;
`endif
  localparam int CNT_W = $clog2(NO_OF_DIGITS + DELTA + 1);
  localparam logic [CNT_W-1:0] LSD_IDX  = CNT_W'(NO_OF_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

  state_t                        state, state_n;
  logic [CNT_W-1:0]              cnt, cnt_n;
  logic [OP_W:0]                 shreg, shreg_n;
  logic signed [RADIX_BITS-1:0]  out_n;
  logic                          valid_n, first_n, last_n;
  logic                          xfer, accept;
  logic [OP_W:0]                 sh_load, sh_next;

  // Booth digit from {b(2k+1), b(2k), b(2k-1)}; result lies in {-2..2}.
  function automatic logic signed [RADIX_BITS-1:0] booth(input logic [2:0] b);
    logic signed [2:0] d;
    case (b)
      3'b001, 3'b010: d = 3'sd1;
      3'b011:         d = 3'sd2;
      3'b100:         d = -3'sd2;
      3'b101, 3'b110: d = -3'sd1;
      default:        d = 3'sd0;
    endcase
    return RADIX_BITS'(d);
  endfunction

  assign xfer     = dig_valid & dig_ready;
  assign in_ready = ~reset & ((state == IDLE) | (xfer & dig_last));
  assign accept   = in_valid & in_ready;
  // Bit 0 of the shift register is the appended b(-1)=0.
  assign sh_load  = {in_data, 1'b0};
  assign sh_next  = {shreg[OP_W-2:0], 2'b00};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    out_n   = dig_out;
    valid_n = dig_valid;
    first_n = dig_first;
    last_n  = dig_last;
    if (xfer) begin
      cnt_n   = cnt + 1'b1;
      first_n = 1'b0;
      last_n  = (cnt_n == LAST_IDX);
      if (dig_last) begin
        state_n = IDLE;
        cnt_n   = '0;
        out_n   = '0;
        valid_n = 1'b0;
        last_n  = 1'b0;
      end else if (state == SEND && cnt != LSD_IDX) begin
        shreg_n = sh_next;
        out_n   = booth(sh_next[OP_W:OP_W-2]);
      end
`ifdef RADIX4_SERIALIZER_FLUSH_EN
      else begin
        state_n = FLUSH;
        out_n   = '0;
      end
`endif
    end
    // A new operand may land on the same edge that retires the last digit.
    if (accept) begin
      state_n = SEND;
      cnt_n   = '0;
      shreg_n = sh_load;
      out_n   = booth(sh_load[OP_W:OP_W-2]);
      valid_n = 1'b1;
      first_n = 1'b1;
      last_n  = (LAST_IDX == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dig_out   <= '0;
      dig_valid <= 1'b0;
      dig_first <= 1'b0;
      dig_last  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dig_out   <= out_n;
      dig_valid <= valid_n;
      dig_first <= first_n;
      dig_last  <= last_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

endmodule
